// File: rtl/simplerisc_pkg.sv
// Shared types and constants for the simplerisc fetch front end.
package simplerisc_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC      = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP       = 32'd4;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Clear the byte-offset bits of a branch target.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: computes the next PC and drives the instruction-fetch
// handshake. The program counter itself lives at the top level and is fed
// from pcnext; this block holds the fetch FSM, the deferred-redirect
// register, the pending-halt flag, the misalignment flag and the
// consumed-instruction counter.
module fetch_sequencer
  import simplerisc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcnext,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            dec_ready,
  output logic            instr_valid,
  input  logic            branch_valid,
  input  logic [XLEN-1:0] branch_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic            halted,
  output logic            misalign_err,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_t    state_q;
  fetch_state_t    state_d;

  logic            redir_pend_q;
  logic            redir_pend_d;
  logic [XLEN-1:0] redir_target_q;
  logic [XLEN-1:0] redir_target_d;
  logic            halt_pend_q;
  logic            halt_pend_d;

  logic            in_req;
  logic            hs;
  logic            stall;
  logic [XLEN-1:0] br_tgt;

  // The fetch address is always the current PC; it cannot move while a
  // request is outstanding because pcnext holds pc during a stall.
  assign imem_addr = pc;

  // Next-state, next-PC, redirect bookkeeping and the consume strobe.
  always_comb begin
    state_d        = state_q;
    pcnext         = pc;
    redir_pend_d   = redir_pend_q;
    redir_target_d = redir_target_q;
    halt_pend_d    = halt_pend_q;

    in_req = (state_q == REQ);
    hs     = in_req & imem_ready;
    stall  = in_req & ~imem_ready;
    br_tgt = align_pc(branch_target);

    instr_valid = hs & dec_ready & ~redir_pend_q & ~branch_valid;

    // Next PC, highest priority first. A branch during a stall cannot move
    // the address, so it is deferred into the redirect register instead.
    if (branch_valid && !stall) begin
      pcnext = br_tgt;
    end else if (hs && redir_pend_q) begin
      pcnext = redir_target_q;
    end else if (hs && dec_ready) begin
      pcnext = pc + PC_STEP;
    end

    // Newest branch during a stall wins; any completion retires the redirect.
    if (branch_valid && stall) begin
      redir_pend_d   = 1'b1;
      redir_target_d = br_tgt;
    end
    if (hs) begin
      redir_pend_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (hs) begin
          halt_pend_d = 1'b0;
          if (halt_req || halt_pend_q) begin
            state_d = HALT;
          end
        end else if (halt_req) begin
          halt_pend_d = 1'b1;
        end
      end
      HALT: begin
        if (resume) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, redirect and halt-pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      redir_pend_q   <= 1'b0;
      redir_target_q <= RESET_PC;
      halt_pend_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      redir_pend_q   <= redir_pend_d;
      redir_target_q <= redir_target_d;
      halt_pend_q    <= halt_pend_d;
    end
  end

  // Registered status outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_req <= 1'b0;
      halted   <= 1'b0;
    end else begin
      imem_req <= (state_d == REQ);
      halted   <= (state_d == HALT);
    end
  end

  // Sticky misaligned-branch flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (branch_valid && (branch_target[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

  // Consumed-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (instr_valid) begin
      fetch_count <= fetch_count + XLEN'(1);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed vector table, hand-written reset
// sequences and randomized stimulus against a transaction-level model.
module tb_fetch_sequencer;
  import simplerisc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] pcnext;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        dec_ready = 1'b0;
  logic        instr_valid;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Program counter register as wired at the top level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pcnext;
  end

  fetch_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .pcnext       (pcnext),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .dec_ready    (dec_ready),
    .instr_valid  (instr_valid),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .halt_req     (halt_req),
    .resume       (resume),
    .halted       (halted),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  // ---------------- reference model ----------------
  // Mode: 0 = waiting to start, 1 = fetching, 2 = stopped.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_redirect_q[$];
  bit          m_halt_armed;
  bit          m_err;
  logic [31:0] m_cnt;
  logic [31:0] e_pcnext;
  bit          e_valid;

  task automatic model_reset();
    m_mode = 0;
    m_pc = RESET_PC;
    m_redirect_q.delete();
    m_halt_armed = 0;
    m_err = 0;
    m_cnt = 32'h0;
  endtask

  task automatic model_eval();
    bit fetching, done, waiting;
    logic [31:0] tgt;
    fetching = (m_mode == 1);
    done     = fetching && imem_ready;
    waiting  = fetching && !imem_ready;
    tgt      = {branch_target[31:2], 2'b00};
    e_valid  = done && dec_ready && (m_redirect_q.size() == 0) && !branch_valid;
    if (branch_valid && !waiting)              e_pcnext = tgt;
    else if (done && m_redirect_q.size() != 0) e_pcnext = m_redirect_q[$];
    else if (done && dec_ready)                e_pcnext = m_pc + 32'd4;
    else                                       e_pcnext = m_pc;
  endtask

  task automatic model_commit();
    bit fetching, done;
    model_eval();
    fetching = (m_mode == 1);
    done     = fetching && imem_ready;
    if (branch_valid && branch_target[1:0] != 2'b00) m_err = 1;
    if (fetching && !done && branch_valid) m_redirect_q.push_back({branch_target[31:2], 2'b00});
    if (done) m_redirect_q.delete();
    if (e_valid) m_cnt = m_cnt + 32'd1;
    m_pc = e_pcnext;
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (done) begin
          if (halt_req || m_halt_armed) m_mode = 2;
          m_halt_armed = 0;
        end else if (halt_req) begin
          m_halt_armed = 1;
        end
      end
      default: if (resume) m_mode = 1;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_now(input string tag);
    model_eval();
    chk({tag, "_addr"},   imem_addr, m_pc);
    chk({tag, "_pcnext"}, pcnext, e_pcnext);
    chk({tag, "_valid"},  32'(instr_valid), 32'(e_valid));
    chk({tag, "_req"},    32'(imem_req), 32'(m_mode == 1));
    chk({tag, "_halted"}, 32'(halted), 32'(m_mode == 2));
    chk({tag, "_err"},    32'(misalign_err), 32'(m_err));
    chk({tag, "_count"},  fetch_count, m_cnt);
  endtask

  task automatic run_cycle(input string tag);
    @(negedge clk);
    check_now(tag);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  // Assert reset mid-cycle, check outputs asynchronously, release after the next edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_now(tag);
    chk({tag, "_req_off"}, 32'(imem_req), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit ir, input bit dr, input bit bv, input logic [31:0] bt,
                       input bit hr, input bit rs);
    imem_ready = ir;
    dec_ready = dr;
    branch_valid = bv;
    branch_target = bt;
    halt_req = hr;
    resume = rs;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          ir, dr, bv;
    logic [31:0] bt;
    bit          hr, rs;
    logic [31:0] e_addr, e_pcn;
    bit          e_v, e_req, e_h, e_err;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input bit ir, input bit dr, input bit bv, input logic [31:0] bt,
                              input bit hr, input bit rs, input logic [31:0] ea,
                              input logic [31:0] ep, input bit ev, input bit er, input bit eh,
                              input bit ee, input logic [31:0] ec);
    vec_t v;
    v.ir = ir; v.dr = dr; v.bv = bv; v.bt = bt; v.hr = hr; v.rs = rs;
    v.e_addr = ea; v.e_pcn = ep; v.e_v = ev; v.e_req = er; v.e_h = eh; v.e_err = ee;
    v.e_cnt = ec;
    return v;
  endfunction

  localparam int NV = 27;
  vec_t tbl[NV];

  initial begin
    string tag;
    bit ir, dr, bv, hr, rs;
    logic [31:0] bt;

    // ir dr bv target   hr rs | addr   pcnext  v req h err count
    tbl[0]  = mk(1, 1, 0, 32'h0,   0, 0, 32'h00,  32'h00,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 32'h0,   0, 0, 32'h00,  32'h04,  1, 1, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 32'h0,   0, 0, 32'h04,  32'h08,  1, 1, 0, 0, 1);
    tbl[3]  = mk(1, 1, 0, 32'h0,   0, 0, 32'h08,  32'h0C,  1, 1, 0, 0, 2);
    tbl[4]  = mk(1, 1, 0, 32'h0,   0, 0, 32'h0C,  32'h10,  1, 1, 0, 0, 3);
    tbl[5]  = mk(0, 1, 0, 32'h0,   0, 0, 32'h10,  32'h10,  0, 1, 0, 0, 4);
    tbl[6]  = mk(0, 1, 0, 32'h0,   0, 0, 32'h10,  32'h10,  0, 1, 0, 0, 4);
    tbl[7]  = mk(0, 1, 0, 32'h0,   0, 0, 32'h10,  32'h10,  0, 1, 0, 0, 4);
    tbl[8]  = mk(1, 1, 0, 32'h0,   0, 0, 32'h10,  32'h14,  1, 1, 0, 0, 4);
    tbl[9]  = mk(1, 1, 0, 32'h0,   0, 0, 32'h14,  32'h18,  1, 1, 0, 0, 5);
    tbl[10] = mk(1, 1, 0, 32'h0,   0, 0, 32'h18,  32'h1C,  1, 1, 0, 0, 6);
    tbl[11] = mk(1, 1, 0, 32'h0,   0, 0, 32'h1C,  32'h20,  1, 1, 0, 0, 7);
    tbl[12] = mk(0, 1, 1, 32'h100, 0, 0, 32'h20,  32'h20,  0, 1, 0, 0, 8);
    tbl[13] = mk(0, 1, 1, 32'h200, 0, 0, 32'h20,  32'h20,  0, 1, 0, 0, 8);
    tbl[14] = mk(1, 1, 0, 32'h0,   0, 0, 32'h20,  32'h200, 0, 1, 0, 0, 8);
    tbl[15] = mk(1, 1, 0, 32'h0,   0, 0, 32'h200, 32'h204, 1, 1, 0, 0, 8);
    tbl[16] = mk(1, 0, 0, 32'h0,   0, 0, 32'h204, 32'h204, 0, 1, 0, 0, 9);
    tbl[17] = mk(1, 1, 0, 32'h0,   0, 0, 32'h204, 32'h208, 1, 1, 0, 0, 9);
    tbl[18] = mk(1, 1, 1, 32'h103, 0, 0, 32'h208, 32'h100, 0, 1, 0, 0, 10);
    tbl[19] = mk(1, 1, 0, 32'h0,   0, 0, 32'h100, 32'h104, 1, 1, 0, 1, 10);
    tbl[20] = mk(1, 1, 0, 32'h0,   0, 0, 32'h104, 32'h108, 1, 1, 0, 1, 11);
    tbl[21] = mk(1, 1, 1, 32'h40,  0, 0, 32'h108, 32'h40,  0, 1, 0, 1, 12);
    tbl[22] = mk(1, 1, 0, 32'h0,   1, 0, 32'h40,  32'h44,  1, 1, 0, 1, 12);
    tbl[23] = mk(1, 1, 0, 32'h0,   1, 0, 32'h44,  32'h44,  0, 0, 1, 1, 13);
    tbl[24] = mk(1, 1, 0, 32'h0,   1, 1, 32'h44,  32'h44,  0, 0, 1, 1, 13);
    tbl[25] = mk(1, 1, 0, 32'h0,   0, 0, 32'h44,  32'h48,  1, 1, 0, 1, 13);
    tbl[26] = mk(1, 1, 0, 32'h0,   0, 0, 32'h48,  32'h4C,  1, 1, 0, 1, 14);

    // Reset state while held in reset.
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_now("rst");
    rst_n = 1'b1;

    // Directed table, checked against both the table and the model.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ir, tbl[i].dr, tbl[i].bv, tbl[i].bt, tbl[i].hr, tbl[i].rs);
      @(negedge clk);
      tag = $sformatf("t%0d", i);
      check_now({tag, "_m"});
      chk({tag, "_addr"},   imem_addr, tbl[i].e_addr);
      chk({tag, "_pcnext"}, pcnext, tbl[i].e_pcn);
      chk({tag, "_valid"},  32'(instr_valid), 32'(tbl[i].e_v));
      chk({tag, "_req"},    32'(imem_req), 32'(tbl[i].e_req));
      chk({tag, "_halted"}, 32'(halted), 32'(tbl[i].e_h));
      chk({tag, "_err"},    32'(misalign_err), 32'(tbl[i].e_err));
      chk({tag, "_count"},  fetch_count, tbl[i].e_cnt);
      @(posedge clk);
      model_commit();
      #1;
    end

    // Reset mid-fetch with a redirect pending: request drops, redirect is lost.
    drive(0, 1, 1, 32'h300, 0, 0);
    run_cycle("a_pend");
    drive(0, 1, 0, 32'h0, 0, 0);
    @(negedge clk);
    #2;
    do_reset("a_rst");
    drive(1, 1, 0, 32'h0, 0, 0);
    run_cycle("a_idle");
    @(negedge clk);
    check_now("a_req");
    chk("a_nolost_pcnext", pcnext, 32'h4);
    @(posedge clk);
    model_commit();
    #1;

    // Reset while halted: every output returns to its reset value.
    drive(1, 1, 0, 32'h0, 1, 0);
    run_cycle("b_halt");
    drive(1, 1, 0, 32'h0, 0, 0);
    run_cycle("b_halted");
    @(negedge clk);
    #2;
    do_reset("b_rst");
    chk("b_rst_halted", 32'(halted), 32'h0);
    chk("b_rst_count", fetch_count, 32'h0);
    run_cycle("b_idle");

    // Randomized stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      ir = ($urandom_range(0, 3) != 0);
      dr = ($urandom_range(0, 3) != 0);
      bv = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 3))
        0:       bt = $urandom;
        1:       bt = $urandom & 32'hFFFF_FFFC;
        2:       bt = 32'hFFFF_FFFC;
        default: bt = 32'($urandom_range(0, 63)) << 2;
      endcase
      hr = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 3) == 0);
      drive(ir, dr, bv, bt, hr, rs);
      if ($urandom_range(0, 499) == 0) begin
        do_reset($sformatf("r%0d_rst", n));
      end else begin
        run_cycle($sformatf("r%0d", n));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
